// File: rtl/j4_io_hub.sv
// j4 core I/O stage: per-slot inbox FIFOs, requester-ID readback and slot-kill register.
// Optional build macro J4_IO_HUB_TICKS_EN adds a 32-bit cycle counter readable at 0x1002/0x1004.
module j4_io_hub #(
  parameter int WIDTH      = 16,
  parameter int MBOX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [WIDTH-1:0] io_dout,
  input  logic [1:0]       io_slot,
  output logic [WIDTH-1:0] io_din,
  output logic [3:0]       kill_slot_rq,
  output logic [3:0]       mbox_nonempty
);
  localparam int AW = $clog2(MBOX_DEPTH);

  logic             r_rd;
  logic             r_wr;
  logic [15:0]      r_addr;
  logic [WIDTH-1:0] r_dout;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_mem [4][MBOX_DEPTH];
  logic [AW:0]      r_rdp [4];
  logic [AW:0]      r_wrp [4];
  logic [3:0]       r_ovf;
  logic [3:0]       r_kill;

  logic             w_rd;
  logic             w_wr;
  logic [3:0]       w_nempty;
  logic [3:0]       w_full;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic [1:0]       w_push_n;
  logic [3:0]       w_ovf_set;
  logic [3:0]       w_ovf_clr;
  logic [3:0]       w_kill;
  logic [WIDTH-1:0] w_din;

`ifdef J4_IO_HUB_TICKS_EN
  logic [31:0] r_cnt;
  logic [15:0] r_shadow;
`endif

  // Single request stage: every core-side signal captured once, unconditionally.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= 16'h0000;
      r_dout <= {WIDTH{1'b0}};
      r_slot <= 2'd0;
    end else begin
      r_rd   <= io_rd;
      r_wr   <= io_wr;
      r_addr <= io_addr;
      r_dout <= io_dout;
      r_slot <= io_slot;
    end
  end

  // Request decode; a simultaneous rd+wr is a write.
  always_comb begin
    w_rd       = r_rd & ~r_wr;
    w_wr       = r_wr;
    for (int n = 0; n < 4; n++) begin
      w_nempty[n] = (r_rdp[n] != r_wrp[n]);
      w_full[n]   = (r_rdp[n][AW-1:0] == r_wrp[n][AW-1:0]) && (r_rdp[n][AW] != r_wrp[n][AW]);
    end
    w_pop      = w_rd && (r_addr == 16'h2000) && w_nempty[r_slot];
    w_push_n   = r_addr[1:0];
    w_push_req = w_wr && (r_addr[15:2] == 14'h0800);
    w_push     = w_push_req && !w_full[w_push_n];
    w_ovf_set  = 4'b0000;
    if (w_push_req && w_full[w_push_n]) begin
      w_ovf_set[w_push_n] = 1'b1;
    end else begin
      w_ovf_set = 4'b0000;
    end
    w_ovf_clr  = (w_wr && (r_addr == 16'h2004)) ? r_dout[3:0] : 4'b0000;
    w_kill     = (w_wr && (r_addr == 16'h4000)) ? r_dout[3:0] : 4'b0000;
  end

  // Read-data mux; any non-read cycle or unmapped address returns zero.
  always_comb begin
    w_din = {WIDTH{1'b0}};
    if (w_rd) begin
      case (r_addr)
        16'h1000: w_din = WIDTH'(r_slot);
        16'h2000: w_din = w_nempty[r_slot] ? r_mem[r_slot][r_rdp[r_slot][AW-1:0]] : {WIDTH{1'b0}};
        16'h2004: w_din = WIDTH'({4'h0, r_ovf, w_full, w_nempty});
`ifdef J4_IO_HUB_TICKS_EN
        16'h1002: w_din = WIDTH'(r_cnt[15:0]);
        16'h1004: w_din = WIDTH'(r_shadow);
`endif
        default:  w_din = {WIDTH{1'b0}};
      endcase
    end else begin
      w_din = {WIDTH{1'b0}};
    end
  end

  // Inbox pointers, overflow flags and kill pulse; a kill flushes by snapping rd to wr.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int n = 0; n < 4; n++) begin
        r_rdp[n] <= '0;
        r_wrp[n] <= '0;
      end
      r_ovf  <= 4'b0000;
      r_kill <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_kill[n]) begin
          r_rdp[n] <= r_wrp[n];
        end else if (w_pop && (r_slot == 2'(n))) begin
          r_rdp[n] <= r_rdp[n] + 1'b1;
        end
        if (w_push && (w_push_n == 2'(n))) begin
          r_wrp[n] <= r_wrp[n] + 1'b1;
        end
      end
      r_ovf  <= (r_ovf & ~w_ovf_clr & ~w_kill) | w_ovf_set;
      r_kill <= w_kill;
    end
  end

  // Inbox storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_push_n][r_wrp[w_push_n][AW-1:0]] <= r_dout;
    end
  end

`ifdef J4_IO_HUB_TICKS_EN
  // Free-running counter; reading the low half snapshots the high half.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_cnt    <= 32'd0;
      r_shadow <= 16'h0000;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_rd && (r_addr == 16'h1002)) begin
        r_shadow <= r_cnt[31:16];
      end
    end
  end
`endif

  assign io_din        = w_din;
  assign kill_slot_rq  = r_kill;
  assign mbox_nonempty = w_nempty;
endmodule
